// File: rtl/time_counter.sv
// ============================================================================
// time_counter
//   12-hour wall clock with AM/PM flag. A prescaler divides CLK down to a
//   one-second tick. Ticks advance a hidden seconds counter, and seconds carry
//   into minutes and then into hours. While SET_TIME is high, timekeeping is
//   frozen and the HRS_INC / MINS_INC strobes step the displayed time
//   directly. Every output comes straight from a flop.
//
// Parameters
//   CLK_DIV     CLK cycles per second of timekeeping (2..65535)
//
// Ports
//   CLK         clock, rising edge
//   RESET_N     asynchronous active-low reset -> 12:00:00 AM
//   SET_TIME    1 = set mode (counting frozen, increment strobes honoured)
//   HRS_INC     hour increment strobe (set mode only)
//   MINS_INC    minute increment strobe (set mode only, no carry into hours)
//   TIME_HRS    current hour, 1..12
//   TIME_MINS   current minute, 0..59
//   TIME_AM_PM  0 = AM, 1 = PM
//   TIME_SECS   current second, 0..59 (present only when the optional
//               build macro TIME_COUNTER_SECS_OUT_EN is defined)
//
// Build option
//   TIME_COUNTER_SECS_OUT_EN  adds the TIME_SECS output port
// ============================================================================
module time_counter #(
   parameter int CLK_DIV = 256
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       SET_TIME,
   input  logic       HRS_INC,
   input  logic       MINS_INC,
   output logic [3:0] TIME_HRS,
   output logic [5:0] TIME_MINS,
   output logic       TIME_AM_PM
`ifdef TIME_COUNTER_SECS_OUT_EN
   ,
   output logic [5:0] TIME_SECS
`endif
);

   localparam int             PW        = $clog2(CLK_DIV);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

   // state
   logic [PW-1:0] presc_q, presc_d;
   logic [5:0]    secs_q,  secs_d;
   logic [5:0]    mins_d;
   logic [3:0]    hrs_d;
   logic          ampm_d;

   // advance strobes
   logic          tick;
   logic          sec_wrap;
   logic          min_adv;
   logic          min_wrap;
   logic          hr_adv;

   // -------------------------------------------------------------------------
   // Advance decode. In set mode the strobes replace the carry chain: a
   // minute strobe never carries into hours, so hr_adv comes only from
   // HRS_INC there. In run mode the strobes are ignored entirely.
   // -------------------------------------------------------------------------
   always_comb begin
      tick     = !SET_TIME && (presc_q == PRESC_MAX);
      sec_wrap = tick && (secs_q == 6'd59);
      min_adv  = SET_TIME ? MINS_INC : sec_wrap;
      min_wrap = min_adv && (TIME_MINS == 6'd59);
      hr_adv   = SET_TIME ? HRS_INC : min_wrap;
   end

   // -------------------------------------------------------------------------
   // Next-state
   // -------------------------------------------------------------------------
   always_comb begin
      presc_d = presc_q;
      secs_d  = secs_q;
      mins_d  = TIME_MINS;
      hrs_d   = TIME_HRS;
      ampm_d  = TIME_AM_PM;

      // Prescaler and seconds sit at zero in set mode. This lets the first
      // tick after release arrive a full CLK_DIV cycles later.
      if (SET_TIME) begin
         presc_d = '0;
         secs_d  = '0;
      end else if (tick) begin
         presc_d = '0;
         secs_d  = (secs_q == 6'd59) ? 6'd0 : secs_q + 6'd1;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      if (min_adv)
         mins_d = (TIME_MINS == 6'd59) ? 6'd0 : TIME_MINS + 6'd1;

      // 12 -> 1 -> ... -> 11 -> 12. The meridiem flips entering 12.
      if (hr_adv) begin
         hrs_d = (TIME_HRS == 4'd12) ? 4'd1 : TIME_HRS + 4'd1;
         if (TIME_HRS == 4'd11)
            ampm_d = ~TIME_AM_PM;
      end
   end

   // -------------------------------------------------------------------------
   // Registers. The outputs are the state flops themselves.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         presc_q    <= '0;
         secs_q     <= '0;
         TIME_MINS  <= '0;
         TIME_HRS   <= 4'd12;
         TIME_AM_PM <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         secs_q     <= secs_d;
         TIME_MINS  <= mins_d;
         TIME_HRS   <= hrs_d;
         TIME_AM_PM <= ampm_d;
      end
   end

`ifdef TIME_COUNTER_SECS_OUT_EN
   assign TIME_SECS = secs_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
// ============================================================================
// tb_time_counter
//   Directed and randomized bench for time_counter with CLK_DIV=4. The
//   reference keeps the time as a minute-of-day (0..1439) plus the seconds
//   and cycles elapsed since the last second boundary. The 12-hour display
//   is derived from the minute-of-day with plain arithmetic.
// ============================================================================
module tb_time_counter;

   localparam int CDIV = 4;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       SET_TIME = 1'b0;
   logic       HRS_INC = 1'b0;
   logic       MINS_INC = 1'b0;
   logic [3:0] TIME_HRS;
   logic [5:0] TIME_MINS;
   logic       TIME_AM_PM;
`ifdef TIME_COUNTER_SECS_OUT_EN
   logic [5:0] TIME_SECS;
`endif

   time_counter #(.CLK_DIV(CDIV)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .SET_TIME   (SET_TIME),
      .HRS_INC    (HRS_INC),
      .MINS_INC   (MINS_INC),
      .TIME_HRS   (TIME_HRS),
      .TIME_MINS  (TIME_MINS),
      .TIME_AM_PM (TIME_AM_PM)
`ifdef TIME_COUNTER_SECS_OUT_EN
      ,
      .TIME_SECS  (TIME_SECS)
`endif
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   // reference state
   int m_mod = 0;   // minute of day, 0 = 12:00 AM
   int m_sec = 0;
   int m_cyc = 0;   // cycles elapsed in the current second

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_hrs();
      int h;
      h = (m_mod / 60) % 12;
      return (h == 0) ? 12 : h;
   endfunction

   function automatic int exp_ampm();
      return (m_mod >= 720) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_mod = 0;
      m_sec = 0;
      m_cyc = 0;
   endtask

   // Apply one rising edge to the reference, using the inputs held across it.
   task automatic model_edge();
      int h, mi;
      if (SET_TIME) begin
         m_cyc = 0;
         m_sec = 0;
         h  = m_mod / 60;
         mi = m_mod % 60;
         if (HRS_INC)  h  = (h + 1) % 24;
         if (MINS_INC) mi = (mi + 1) % 60;
         m_mod = h * 60 + mi;
      end else begin
         m_cyc++;
         if (m_cyc == CDIV) begin
            m_cyc = 0;
            m_sec++;
            if (m_sec == 60) begin
               m_sec = 0;
               m_mod = (m_mod + 1) % 1440;
            end
         end
      end
   endtask

   task automatic cmp(input string tag);
      chk({tag, ".hrs"},  TIME_HRS,   exp_hrs());
      chk({tag, ".mins"}, TIME_MINS,  m_mod % 60);
      chk({tag, ".ampm"}, TIME_AM_PM, exp_ampm());
`ifdef TIME_COUNTER_SECS_OUT_EN
      chk({tag, ".secs"}, TIME_SECS,  m_sec);
`endif
   endtask

   // One clock: edge, update reference, sample 1 time unit later.
   task automatic step(input string tag);
      @(posedge CLK);
      model_edge();
      #1;
      cmp(tag);
   endtask

   task automatic do_reset();
      RESET_N  = 1'b0;
      SET_TIME = 1'b0;
      HRS_INC  = 1'b0;
      MINS_INC = 1'b0;
      @(negedge CLK);
      model_reset();
      #1;
      chk("rst.hrs",  TIME_HRS,   12);
      chk("rst.mins", TIME_MINS,  0);
      chk("rst.ampm", TIME_AM_PM, 0);
`ifdef TIME_COUNTER_SECS_OUT_EN
      chk("rst.secs", TIME_SECS,  0);
`endif
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   // Set mode: nh hour strobes and nm minute strobes, overlapped from cycle 0.
   task automatic set_pulses(input int nh, input int nm);
      int n;
      n = (nh > nm) ? nh : nm;
      SET_TIME = 1'b1;
      for (int i = 0; i < n; i++) begin
         HRS_INC  = (i < nh);
         MINS_INC = (i < nm);
         step("set");
      end
      HRS_INC  = 1'b0;
      MINS_INC = 1'b0;
   endtask

   initial begin
      // ---- reset, then one full minute of run mode
      do_reset();
      for (int i = 1; i <= 240; i++) begin
         step("run1");
`ifdef TIME_COUNTER_SECS_OUT_EN
         if (i == 236) chk("secs59", TIME_SECS, 59);
`endif
         if (i == 239) chk("min1.pre", TIME_MINS, 0);
      end
      chk("min1.mins", TIME_MINS, 1);
      chk("min1.hrs",  TIME_HRS,  12);
      chk("min1.ampm", TIME_AM_PM, 0);
`ifdef TIME_COUNTER_SECS_OUT_EN
      chk("min1.secs", TIME_SECS, 0);
`endif

      // ---- 11:59 AM rolls into 12:00 PM
      do_reset();
      set_pulses(11, 59);
      SET_TIME = 1'b0;
      for (int i = 1; i < 240; i++) step("am2pm");
      chk("am2pm.pre.hrs",  TIME_HRS,   11);
      chk("am2pm.pre.mins", TIME_MINS,  59);
      chk("am2pm.pre.ampm", TIME_AM_PM, 0);
      step("am2pm");
      chk("am2pm.hrs",  TIME_HRS,   12);
      chk("am2pm.mins", TIME_MINS,  0);
      chk("am2pm.ampm", TIME_AM_PM, 1);

      // ---- 11:59 PM rolls into 12:00 AM
      do_reset();
      set_pulses(23, 59);
      SET_TIME = 1'b0;
      for (int i = 0; i < 240; i++) step("pm2am");
      chk("pm2am.hrs",  TIME_HRS,   12);
      chk("pm2am.ampm", TIME_AM_PM, 0);

      // ---- twelve hour strobes from 12:00 AM
      do_reset();
      SET_TIME = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         HRS_INC = 1'b1;
         step("hinc");
         chk("hinc.hrs",  TIME_HRS,   i);
         chk("hinc.ampm", TIME_AM_PM, (i == 12) ? 1 : 0);
      end
      HRS_INC = 1'b0;

      // ---- both strobes together from 12:59: no minute carry into hours
      do_reset();
      set_pulses(0, 59);
      HRS_INC  = 1'b1;
      MINS_INC = 1'b1;
      step("both");
      chk("both.mins", TIME_MINS,  0);
      chk("both.hrs",  TIME_HRS,   1);
      chk("both.ampm", TIME_AM_PM, 0);
      HRS_INC  = 1'b0;
      MINS_INC = 1'b0;
      SET_TIME = 1'b0;

      // ---- strobes ignored in run mode, then async reset at 3:27 PM
      do_reset();
      for (int i = 0; i < 300; i++) begin
         HRS_INC  = $urandom_range(1);
         MINS_INC = $urandom_range(1);
         step("ign");
      end
      HRS_INC  = 1'b0;
      MINS_INC = 1'b0;
      set_pulses(15 - (m_mod / 60), 27 - (m_mod % 60));
      SET_TIME = 1'b0;
      for (int i = 0; i < 100; i++) begin
         HRS_INC  = $urandom_range(1);
         MINS_INC = $urandom_range(1);
         step("ign2");
      end
      HRS_INC  = 1'b0;
      MINS_INC = 1'b0;
      chk("327.hrs",  TIME_HRS,   3);
      chk("327.mins", TIME_MINS,  27);
      chk("327.ampm", TIME_AM_PM, 1);
      #2 RESET_N = 1'b0;
      #1;
      model_reset();
      chk("arst.hrs",  TIME_HRS,   12);
      chk("arst.mins", TIME_MINS,  0);
      chk("arst.ampm", TIME_AM_PM, 0);
      #3 RESET_N = 1'b1;
      for (int i = 0; i < 20; i++) step("post");

      // ---- randomized set/run phases
      do_reset();
      for (int p = 0; p < 24; p++) begin
         int len;
         SET_TIME = $urandom_range(1);
         len = SET_TIME ? $urandom_range(40, 1) : $urandom_range(500, 1);
         for (int i = 0; i < len; i++) begin
            HRS_INC  = ($urandom_range(3) == 0);
            MINS_INC = ($urandom_range(1) == 0);
            step("rnd");
         end
      end
      SET_TIME = 1'b0;
      HRS_INC  = 1'b0;
      MINS_INC = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 256: CLK cycles per one second of timekeeping, legal range 2..65535.
REQ-002 CLK  input  1  The block SHALL use CLK as its single clock; all state updates on the rising edge.
REQ-003 RESET_N  input  1  The block SHALL use RESET_N as its asynchronous, active-low reset.
REQ-004 SET_TIME  input  1  The block SHALL treat SET_TIME=1 as set mode: timekeeping frozen, increments enabled.
REQ-005 HRS_INC  input  1  The block SHALL treat HRS_INC as a one-cycle hour-increment strobe, honoured only in set mode.
REQ-006 MINS_INC  input  1  The block SHALL treat MINS_INC as a one-cycle minute-increment strobe, honoured only in set mode.
REQ-007 TIME_HRS  output  4  The block SHALL drive the current hour on TIME_HRS, legal values 1..12.
REQ-008 TIME_MINS  output  6  The block SHALL drive the current minute on TIME_MINS, legal values 0..59.
REQ-009 TIME_AM_PM  output  1  The block SHALL drive TIME_AM_PM as 0=AM, 1=PM.

Function
REQ-010 The block SHALL keep a prescaler counting 0..CLK_DIV-1 and SHALL generate an internal one-cycle tick on the cycle where it equals CLK_DIV-1, then wrap it to 0.
REQ-011 The block SHALL keep an internal seconds counter 0..59, advanced by one on each tick.
REQ-012 The block SHALL, on a tick with seconds=59, wrap seconds to 0 and advance minutes in the same edge.
REQ-013 The block SHALL, when minutes advance from 59, wrap minutes to 0 and advance hours in the same edge.
REQ-014 The block SHALL advance hours 12->1, 1->2, ..., 11->12; TIME_HRS SHALL never take 0 or 13..15.
REQ-015 The block SHALL toggle TIME_AM_PM in the same edge that hours advance 11->12, whether by carry or by HRS_INC.
REQ-016 The block SHALL update outputs on the rising edge that consumes the tick; no additional output latency.
REQ-017 The block SHALL, while SET_TIME=1, hold prescaler and seconds at 0 and generate no ticks.
REQ-018 The block SHALL, in set mode, advance hours by one per cycle with HRS_INC=1, per REQ-014/REQ-015.
REQ-019 The block SHALL, in set mode, advance minutes by one per cycle with MINS_INC=1, wrapping 59->0 with no carry into hours.
REQ-020 The block SHALL apply HRS_INC and MINS_INC independently when both are 1 in the same cycle.
REQ-021 The block SHALL ignore HRS_INC and MINS_INC while SET_TIME=0.
REQ-022 The block SHALL, on the first cycle after SET_TIME falls, resume counting from prescaler=0, seconds=0; the first tick follows CLK_DIV cycles later.
REQ-023 The block SHALL drive all outputs directly from registers (glitch-free for the downstream comparator).

Reset
REQ-024 The block SHALL, while RESET_N=0, asynchronously force TIME_HRS=12, TIME_MINS=0, TIME_AM_PM=0, seconds=0, prescaler=0.
REQ-025 The block SHALL, on reset assertion mid-count or mid-set, discard all progress and return to the REQ-024 values.
REQ-026 The block SHALL start prescaler counting on the first rising CLK edge after RESET_N deasserts, when SET_TIME=0.

Configuration
REQ-027 The block SHALL, with macro TIME_COUNTER_SECS_OUT_EN defined, add output TIME_SECS (6 bits) driving the internal seconds counter, reset value 0.
REQ-028 The block SHALL, without TIME_COUNTER_SECS_OUT_EN, omit the TIME_SECS port and keep all other behaviour identical.

Verification (bench uses CLK_DIV=4)
REQ-029 Reset then 4*60 cycles with SET_TIME=0 -> TIME_MINS=1, TIME_HRS=12, TIME_AM_PM=0 exactly on cycle 240.
REQ-030 Set 11:59 AM in set mode, release, 240 cycles -> 12:00 with TIME_AM_PM=1 on the same edge the minutes wrap.
REQ-031 Set mode from 12:00 AM, 12 HRS_INC pulses -> hours 1..11 then 12, TIME_AM_PM=1 on the twelfth pulse.
REQ-032 Set mode from 12:59, MINS_INC and HRS_INC together in one cycle -> TIME_MINS=0, TIME_HRS=1, TIME_AM_PM unchanged.
REQ-033 SET_TIME=0 with HRS_INC/MINS_INC pulsing -> time changes only on ticks; RESET_N pulse mid-count at 3:27 PM -> 12:00 AM immediately, without waiting for a CLK edge.
REQ-034 With TIME_COUNTER_SECS_OUT_EN, 4*59 cycles after reset -> TIME_SECS=59; 4 more cycles -> TIME_SECS=0, TIME_MINS=1.
